canvas_server: RTL and testbench
================================

CANVAS_SERVER -- requirements
Module: canvas_server

Interface
REQ-001 SHALL have parameter TIMEOUT, default 2048, meaning the number of WAIT-state cycles before a recognition attempt is abandoned (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port pen_valid  input  1  meaning pen_x/pen_y/pen_ink are valid this cycle.
REQ-005 SHALL have port pen_x  input  5  meaning the column index.
REQ-006 SHALL have port pen_y  input  5  meaning the row index.
REQ-007 SHALL have port pen_ink  input  1  meaning the pixel value to write (1 = draw, 0 = erase).
REQ-008 SHALL have port submit  input  1  meaning a one-cycle request to recognize the canvas.
REQ-009 SHALL have port clear  input  1  meaning a one-cycle request to blank the canvas.
REQ-010 SHALL have port end_write  output  1  meaning a one-cycle pulse that starts the recognizer readout.
REQ-011 SHALL have port read_addr  input  10  meaning the recognizer pixel address: [9:5] row, [4:0] column.
REQ-012 SHALL have port read_enable  input  1  meaning the recognizer is reading this cycle.
REQ-013 SHALL have port read_in_data  output  1  meaning the pixel at read_addr.
REQ-014 SHALL have port ready_to_write  input  1  meaning the recognizer result is valid this cycle.
REQ-015 SHALL have port write_data  input  8  meaning the recognized character code.
REQ-016 SHALL have port char_out  output  8  meaning the last accepted character.
REQ-017 SHALL have port char_valid  output  1  meaning a one-cycle pulse when char_out updates.
REQ-018 SHALL have port timeout  output  1  meaning a one-cycle pulse when WAIT expires.
REQ-019 SHALL have port busy  output  1  meaning the state is not DRAW.

Function
REQ-020 SHALL store a 32x32 one-bit canvas addressed as canvas[row][column].
REQ-021 SHALL use the states DRAW, WAIT and CLEAR.
REQ-022 SHALL, in DRAW with pen_valid=1, write pen_ink to canvas[pen_y][pen_x] at the next edge; pen inputs SHALL be ignored in WAIT and CLEAR.
REQ-023 SHALL drive read_in_data combinationally as canvas[read_addr[9:5]][read_addr[4:0]] when read_enable=1, and as 0 otherwise, in every state.
REQ-024 SHALL, when a pen write and a read target the same pixel in the same cycle, return the pre-write value.
REQ-025 SHALL, on submit=1 in DRAW with clear=0, register end_write=1 for exactly the next cycle and enter WAIT.
REQ-026 SHALL, on clear=1 in DRAW, enter CLEAR; clear SHALL take precedence over a simultaneous submit, which is dropped.
REQ-027 SHALL ignore submit and clear outside DRAW.
REQ-028 SHALL, in WAIT, count cycles from 0; on ready_to_write=1, latch char_out<=write_data, pulse char_valid for one cycle, and leave WAIT.
REQ-029 SHALL ignore ready_to_write outside WAIT; char_out SHALL hold its value otherwise.
REQ-030 SHALL, when the WAIT count reaches TIMEOUT-1 without ready_to_write, pulse timeout for one cycle and return to DRAW with the canvas intact; if ready_to_write is asserted in that same cycle, it SHALL win.
REQ-031 SHALL, in CLEAR, zero one row per cycle, rows 0 to 31 in order (32 cycles), and then enter DRAW.
REQ-032 SHALL drive busy=1 in WAIT and CLEAR, and busy=0 in DRAW.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously set state=DRAW, canvas all 0, counters 0, char_out=8'h00, and end_write=char_valid=timeout=busy=0.
REQ-034 SHALL abandon any WAIT or CLEAR in progress on reset; no pulse SHALL be emitted.

Configuration
REQ-035 SHALL, with CANVAS_AUTO_CLEAR_EN defined, go from WAIT to CLEAR after an accepted result, and without it go from WAIT to DRAW, with the canvas retained.

Verification
REQ-036 SHALL check: pen writes (3,4,1) and (31,31,1) in DRAW, then read_addr=10'd131 and 10'd1023 with read_enable=1 -> read_in_data=1; read_addr=10'd0 -> 0.
REQ-037 SHALL check: submit in DRAW -> end_write high exactly one cycle, busy=1; a pen write during WAIT leaves the pixel unchanged.
REQ-038 SHALL check: in WAIT, ready_to_write=1 with write_data=8'd65 -> char_out=8'd65 and a single char_valid pulse; with the macro defined, busy lasts 32 more cycles and the canvas then reads all 0.
REQ-039 SHALL check: TIMEOUT=16, no ready_to_write -> timeout pulse 16 cycles after entering WAIT, state DRAW, and canvas unchanged.
REQ-040 SHALL check: submit and clear together in DRAW -> no end_write, and 32 clear cycles occur.
REQ-041 SHALL check: rst_n low mid-CLEAR (row 10) -> all outputs 0 immediately; after release, busy=0 and the canvas is all 0.

Source files
------------

// File: rtl/canvas_server.sv
// canvas_server: 32x32 one-bit drawing canvas that hands its contents to an
// external recognizer and collects the recognized character code.
// States: DRAW (pen edits), WAIT (recognizer running), CLEAR (row-by-row wipe).
// Optional feature: define CANVAS_AUTO_CLEAR_EN to wipe the canvas
// automatically after each accepted recognition result.
module canvas_server #(
    parameter int TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pen_valid,
    input  logic [4:0] pen_x,
    input  logic [4:0] pen_y,
    input  logic       pen_ink,
    input  logic       submit,
    input  logic       clear,
    output logic       end_write,
    input  logic [9:0] read_addr,
    input  logic       read_enable,
    output logic       read_in_data,
    input  logic       ready_to_write,
    input  logic [7:0] write_data,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        DRAW  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic [4:0]  clr_row, clr_row_n;
    logic        end_write_n, char_valid_n, timeout_n;
    logic        char_load, pen_we, clr_we;

    // Canvas storage, row-major: canvas[row][column].
    logic [31:0] canvas [32];

    // Next-state, counter and pulse decode for the DRAW/WAIT/CLEAR controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_n      = state;
        wait_cnt_n   = wait_cnt;
        clr_row_n    = clr_row;
        end_write_n  = 1'b0;
        char_valid_n = 1'b0;
        timeout_n    = 1'b0;
        char_load    = 1'b0;
        pen_we       = 1'b0;
        clr_we       = 1'b0;
        case (state)
            DRAW: begin
                pen_we = pen_valid;
                if (clear) begin
                    // A simultaneous submit is dropped in favour of the wipe.
                    state_n   = CLEAR;
                    clr_row_n = 5'd0;
                end else if (submit) begin
                    state_n     = WAIT;
                    wait_cnt_n  = 16'd0;
                    end_write_n = 1'b1;
                end
            end
            WAIT: begin
                // A result arriving on the final count still beats the timeout.
                if (ready_to_write) begin
                    char_load    = 1'b1;
                    char_valid_n = 1'b1;
                    clr_row_n    = 5'd0;
`ifdef CANVAS_AUTO_CLEAR_EN
                    state_n      = CLEAR;
`else
                    state_n      = DRAW;
`endif
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = DRAW;
                end else begin
                    wait_cnt_n = wait_cnt + 16'd1;
                end
            end
            CLEAR: begin
                clr_we    = 1'b1;
                clr_row_n = clr_row + 5'd1;
                if (clr_row == 5'd31) begin
                    state_n = DRAW;
                end
            end
            default: state_n = DRAW;
        endcase
    end

    // State, counters, registered pulses and the held character code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DRAW;
            wait_cnt   <= 16'd0;
            clr_row    <= 5'd0;
            end_write  <= 1'b0;
            char_valid <= 1'b0;
            timeout    <= 1'b0;
            char_out   <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            clr_row    <= clr_row_n;
            end_write  <= end_write_n;
            char_valid <= char_valid_n;
            timeout    <= timeout_n;
            if (char_load) begin
                char_out <= write_data;
            end
        end
    end

    // Canvas update: row wipe in CLEAR, single-pixel pen write in DRAW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the canvas must read all-zero right after reset, so it is
            // built from resettable flops rather than an unreset RAM.
            for (int r = 0; r < 32; r++) begin
                canvas[r] <= '0;
            end
        end else if (clr_we) begin
            canvas[clr_row] <= '0;
        end else if (pen_we) begin
            canvas[pen_y][pen_x] <= pen_ink;
        end
    end

    // Recognizer readout is combinational, so a same-cycle pen write is not yet visible.
    assign read_in_data = read_enable ? canvas[read_addr[9:5]][read_addr[4:0]] : 1'b0;

    assign busy = (state != DRAW);

endmodule

// File: tb/tb_canvas_server.sv
// Directed self-checking bench for canvas_server (TIMEOUT overridden to 16).
// Follows CANVAS_AUTO_CLEAR_EN when it is defined for the build.
module tb_canvas_server;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pen_valid;
    logic [4:0] pen_x;
    logic [4:0] pen_y;
    logic       pen_ink;
    logic       submit;
    logic       clear;
    logic       end_write;
    logic [9:0] read_addr;
    logic       read_enable;
    logic       read_in_data;
    logic       ready_to_write;
    logic [7:0] write_data;
    logic [7:0] char_out;
    logic       char_valid;
    logic       timeout;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    canvas_server #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pen_valid      (pen_valid),
        .pen_x          (pen_x),
        .pen_y          (pen_y),
        .pen_ink        (pen_ink),
        .submit         (submit),
        .clear          (clear),
        .end_write      (end_write),
        .read_addr      (read_addr),
        .read_enable    (read_enable),
        .read_in_data   (read_in_data),
        .ready_to_write (ready_to_write),
        .write_data     (write_data),
        .char_out       (char_out),
        .char_valid     (char_valid),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pen_write(input int x, input int y, input logic ink);
        pen_x     = 5'(x);
        pen_y     = 5'(y);
        pen_ink   = ink;
        pen_valid = 1'b1;
        tick();
        pen_valid = 1'b0;
    endtask

    task automatic read_px(input int addr, output logic val);
        read_addr   = 10'(addr);
        read_enable = 1'b1;
        #1;
        val = read_in_data;
        read_enable = 1'b0;
    endtask

    task automatic count_ones(output int ones);
        logic v;
        ones = 0;
        for (int a = 0; a < 1024; a++) begin
            read_px(a, v);
            if (v) ones++;
        end
    endtask

    initial begin
        logic v;
        int   n;
        int   ones;
        int   ew_seen;

        rst_n = 1'b0; pen_valid = 1'b0; pen_x = '0; pen_y = '0; pen_ink = 1'b0;
        submit = 1'b0; clear = 1'b0; read_addr = '0; read_enable = 1'b0;
        ready_to_write = 1'b0; write_data = '0;

        // Reset state
        #3;
        check("rst_busy", busy, 0);
        check("rst_char_out", char_out, 0);
        check("rst_pulses", {end_write, char_valid, timeout}, 0);
        #19 rst_n = 1'b1;
        tick();

        // Pen writes in DRAW and readback
        pen_write(3, 4, 1'b1);
        pen_write(31, 31, 1'b1);
        read_px(131, v);  check("read_131", v, 1);
        read_px(1023, v); check("read_1023", v, 1);
        read_px(0, v);    check("read_0", v, 0);
        read_addr = 10'd131; read_enable = 1'b0; #1;
        check("read_disabled", read_in_data, 0);

        // Same-pixel read during write returns the old value
        pen_x = 5'd3; pen_y = 5'd4; pen_ink = 1'b0; pen_valid = 1'b1;
        read_addr = 10'd131; read_enable = 1'b1; #1;
        check("rw_same_pre", read_in_data, 1);
        tick();
        pen_valid = 1'b0;
        check("rw_same_post", read_in_data, 0);
        read_enable = 1'b0;
        pen_write(3, 4, 1'b1);

        // Submit: one-cycle end_write, busy in WAIT
        submit = 1'b1; tick(); submit = 1'b0;
        check("submit_end_write", end_write, 1);
        check("submit_busy", busy, 1);
        pen_write(5, 5, 1'b1);
        check("end_write_drop", end_write, 0);
        read_px(165, v); check("wait_pen_ignored", v, 0);

        // Recognizer result accepted
        write_data = 8'd65; ready_to_write = 1'b1; tick(); ready_to_write = 1'b0;
        check("char_out_65", char_out, 65);
        check("char_valid_pulse", char_valid, 1);
        tick();
        check("char_valid_drop", char_valid, 0);
`ifdef CANVAS_AUTO_CLEAR_EN
        n = 1;
        while (busy && n < 100) begin tick(); n++; end
        check("auto_clear_cycles", n, 32);
        count_ones(ones); check("auto_clear_canvas", ones, 0);
        pen_write(3, 4, 1'b1);
`else
        check("no_auto_busy", busy, 0);
        read_px(131, v); check("canvas_retained", v, 1);
`endif

        // ready_to_write outside WAIT is ignored
        write_data = 8'd99; ready_to_write = 1'b1; tick(); ready_to_write = 1'b0;
        check("draw_ready_ignored", {char_valid, char_out}, {1'b0, 8'd65});

        // Timeout after 16 WAIT cycles, canvas intact
        submit = 1'b1; tick(); submit = 1'b0;
        n = 0;
        while (!timeout && n < 100) begin tick(); n++; end
        check("timeout_cycles", n, 16);
        check("timeout_busy", busy, 0);
        read_px(131, v); check("timeout_canvas", v, 1);
        tick();
        check("timeout_drop", timeout, 0);

        // Result on the final WAIT cycle beats the timeout
        submit = 1'b1; tick(); submit = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        write_data = 8'h42; ready_to_write = 1'b1; tick(); ready_to_write = 1'b0;
        check("last_cycle_win", {char_valid, timeout, char_out}, {1'b1, 1'b0, 8'h42});
        n = 0;
        while (busy && n < 100) begin tick(); n++; end

        // Submit and clear together: clear wins, 32 clear cycles
        pen_write(3, 4, 1'b1);
        submit = 1'b1; clear = 1'b1; tick(); submit = 1'b0; clear = 1'b0;
        ew_seen = int'(end_write);
        check("clear_busy", busy, 1);
        n = 0;
        while (busy && n < 100) begin tick(); n++; ew_seen += int'(end_write); end
        check("clear_cycles", n, 32);
        check("clear_no_end_write", ew_seen, 0);
        count_ones(ones); check("clear_canvas", ones, 0);

        // Reset in the middle of CLEAR (row 10)
        pen_write(31, 31, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_busy", busy, 1);
        read_addr = 10'd1023; read_enable = 1'b1;
        #2 rst_n = 1'b0; #1;
        check("rst_outputs", {busy, end_write, char_valid, timeout, read_in_data, char_out},
              14'd0);
        read_enable = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        count_ones(ones); check("post_rst_canvas", ones, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
